uart_tx_core: RTL and testbench

- UART transmitter top: accepts a parallel byte with a one-cycle valid strobe and serialises it on TX_OUT.
- Frame is start bit, data LSB first, optional parity, stop bit.
- One bit per CLK cycle; CLK is the pre-divided baud clock, with no internal prescaler.
- Sits between the system register/FIFO side and the serial line; BUSY provides flow control.

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_serializer.sv | 46 ++++
 rtl/uart_tx_core.sv | 93 +++++++++
 tb/tb_uart_tx_core.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic ParEven  = 1'b0;
  localparam logic ParOdd   = 1'b1;
  localparam logic StartBit = 1'b0;
  localparam logic StopBit  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for one UART frame; emits bits LSB first.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  shift_i,
  output logic                  bit_o,
  output logic                  done_o
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_o  = shreg_q[0];
  assign done_o = (cnt_q == CntW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, data LSB first, optional parity, stop bit; one bit per CLK.
module uart_tx_core
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  tx_state_e state_q;
  logic      par_en_q;
  logic      par_bit_q;
  logic      tx_q;
  logic      busy_q;
  logic      accept;
  logic      shift;
  logic      ser_bit;
  logic      ser_done;

  // The stop state also accepts so a held request starts the next frame with no idle gap.
  assign accept = DATA_VALID && ((state_q == StIdle) || (state_q == StStop));
  assign shift  = (state_q == StData);

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk_i  (CLK),
    .rst_ni (RST),
    .load_i (accept),
    .data_i (P_DATA),
    .shift_i(shift),
    .bit_o  (ser_bit),
    .done_o (ser_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= StopBit;
      busy_q    <= 1'b0;
    end else begin
      if (accept) begin
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ (PAR_TYP == ParOdd);
      end
      unique case (state_q)
        StIdle: begin
          tx_q   <= StopBit;
          busy_q <= 1'b0;
          if (accept) state_q <= StStart;
        end
        StStart: begin
          tx_q    <= StartBit;
          busy_q  <= 1'b1;
          state_q <= StData;
        end
        StData: begin
          tx_q   <= ser_bit;
          busy_q <= 1'b1;
          if (ser_done) state_q <= par_en_q ? StParity : StStop;
        end
        StParity: begin
          tx_q    <= par_bit_q;
          busy_q  <= 1'b1;
          state_q <= StStop;
        end
        StStop: begin
          tx_q    <= StopBit;
          busy_q  <= 1'b1;
          state_q <= accept ? StStart : StIdle;
        end
        default: begin
          tx_q    <= StopBit;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core with hand-computed serial frames.
module tb_uart_tx_core;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  uart_tx_core #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .P_DATA    (p_data),
    .DATA_VALID(data_valid),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .TX_OUT    (tx_out),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // seq[n-1] is the first bit on the line; called one step after the acceptance edge.
  // A one-cycle DATA_VALID pulse with 0xFF is injected at step inj (negative = none).
  task automatic frame(input string tag, input logic [10:0] seq, input int n, input int inj,
                       input bit idle_after);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s bit%0d tx", tag, i), tx_out, seq[n-1-i]);
      chk($sformatf("%s bit%0d busy", tag, i), busy, 1'b1);
      if (i == inj) begin
        data_valid = 1'b1;
        p_data     = 8'hFF;
      end else if (i == inj + 1) begin
        data_valid = 1'b0;
      end
    end
    data_valid = 1'b0;
    if (idle_after) begin
      tick();
      chk({tag, " end tx"}, tx_out, 1'b1);
      chk({tag, " end busy"}, busy, 1'b0);
    end
  endtask

  task automatic start(input logic [7:0] d, input logic pe, input logic pt);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    chk("accept edge tx idle", tx_out, 1'b1);
  endtask

  initial begin
    rst        = 1'b0;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    tick();
    chk("reset tx", tx_out, 1'b1);
    chk("reset busy", busy, 1'b0);
    rst = 1'b1;
    tick();
    chk("idle tx", tx_out, 1'b1);
    chk("idle busy", busy, 1'b0);

    // 0xCD, no parity
    start(8'hCD, 1'b0, 1'b0);
    frame("cd", 11'b0101100111, 10, -1, 1'b1);

    // 0x65 odd parity; PAR_TYP flipped mid-frame must not matter
    start(8'h65, 1'b1, 1'b1);
    par_typ = 1'b0;
    frame("odd", 11'b01010011011, 11, -1, 1'b1);

    // 0x65 even parity
    start(8'h65, 1'b1, 1'b0);
    frame("even", 11'b01010011001, 11, -1, 1'b1);

    // Request during a frame is ignored and not queued
    start(8'hCD, 1'b0, 1'b0);
    frame("rej", 11'b0101100111, 10, 3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rej idle%0d tx", i), tx_out, 1'b1);
      chk($sformatf("rej idle%0d busy", i), busy, 1'b0);
    end

    // Back-to-back: held request, second byte taken at the stop-bit boundary
    p_data     = 8'h00;
    par_en     = 1'b0;
    data_valid = 1'b1;
    tick();
    chk("b2b accept tx", tx_out, 1'b1);
    p_data = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("b2b0 bit%0d tx", i), tx_out, (i == 9) ? 1'b1 : 1'b0);
      chk($sformatf("b2b0 bit%0d busy", i), busy, 1'b1);
    end
    data_valid = 1'b0;
    frame("b2b1", 11'b0111111111, 10, -1, 1'b1);

    // Asynchronous reset mid-frame
    start(8'h00, 1'b0, 1'b0);
    tick();
    tick();
    chk("pre-reset tx", tx_out, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async reset tx", tx_out, 1'b1);
    chk("async reset busy", busy, 1'b0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post-reset%0d tx", i), tx_out, 1'b1);
      chk($sformatf("post-reset%0d busy", i), busy, 1'b0);
    end

    // Frame after reset proves the counter restarted cleanly
    start(8'hA5, 1'b1, 1'b0);
    frame("post", 11'b01010010101, 11, -1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
